// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: write stream, two read requesters and the 1024x8 memory command bus.
interface mem_access_ctrl_if #(parameter int DW = 8, parameter int AW = 10);
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_req_a;
  logic          rd_req_b;
  logic          rd_ack_a;
  logic          rd_ack_b;
  logic [DW-1:0] validdata;
  logic          iWriteEnable;
  logic [AW-1:0] iAddress;
  logic [AW-1:0] iReadAddress;
  logic          Readtoa;
  logic          Readtob;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          ovf_err;
  modport slave (
    input  wr_valid, wr_data, rd_req_a, rd_req_b,
    output wr_ready, rd_ack_a, rd_ack_b, validdata, iWriteEnable, iAddress, iReadAddress,
           Readtoa, Readtob, count, full, empty, ovf_err
  );
  modport master (
    output wr_valid, wr_data, rd_req_a, rd_req_b,
    input  wr_ready, rd_ack_a, rd_ack_b, validdata, iWriteEnable, iAddress, iReadAddress,
           Readtoa, Readtob, count, full, empty, ovf_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: circular-FIFO command arbiter for the 1024x8 memory; MEM_CTRL_OVF_DETECT_EN adds sticky ovf_err.
module mem_access_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input logic clk,
  input logic rst_n,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WR, RD} op_t;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  op_t           op, last_op;
  logic          last_rd, sel_b, rd_pend, wr_pend;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  // when both sides are eligible, alternate strictly; last_rd=1 means B was served last
  always_comb begin
    rd_pend = (bus.rd_req_a | bus.rd_req_b) & (cnt != '0);
    wr_pend = bus.wr_valid & (cnt != FULL_CNT);
    op = (wr_pend & rd_pend) ? ((last_op == RD) ? WR : RD) : wr_pend ? WR : rd_pend ? RD : IDLE;
    sel_b = (bus.rd_req_a & bus.rd_req_b) ? !last_rd : bus.rd_req_b;
  end
  assign bus.count    = cnt;
  assign bus.full     = cnt == FULL_CNT;
  assign bus.empty    = cnt == '0;
  assign bus.wr_ready = !bus.full & (!rd_pend | last_op == RD);
  assign bus.rd_ack_a = (op == RD) & !sel_b;
  assign bus.rd_ack_b = (op == RD) & sel_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      cnt              <= '0;
      last_op          <= RD;
      last_rd          <= 1'b1;
      bus.validdata    <= '0;
      bus.iAddress     <= '0;
      bus.iReadAddress <= '0;
      bus.iWriteEnable <= 1'b0;
      bus.Readtoa      <= 1'b0;
      bus.Readtob      <= 1'b0;
    end else begin
      bus.iWriteEnable <= op == WR;
      bus.Readtoa      <= bus.rd_ack_a;
      bus.Readtob      <= bus.rd_ack_b;
      if (op == WR) begin
        bus.validdata <= bus.wr_data;
        bus.iAddress  <= wr_ptr;
        wr_ptr        <= wr_ptr + 1'b1;
        cnt           <= cnt + 1'b1;
        last_op       <= WR;
      end else if (op == RD) begin
        bus.iReadAddress <= rd_ptr;
        rd_ptr           <= rd_ptr + 1'b1;
        cnt              <= cnt - 1'b1;
        last_op          <= RD;
        last_rd          <= sel_b;
      end
    end
  end
`ifdef MEM_CTRL_OVF_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.ovf_err <= 1'b0;
    else if (bus.wr_valid & bus.full) bus.ovf_err <= 1'b1;
  end
`else
  assign bus.ovf_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed stimulus with a command scoreboard popped by a negedge monitor.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  mem_access_ctrl_if #(.DW(8), .AW(10)) bus ();
  mem_access_ctrl #(.DW(8), .AW(10), .DEPTH(1024)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {
    logic       we;
    logic       ra;
    logic       rb;
    logic [9:0] addr;
    logic [7:0] data;
  } cmd_t;
`ifdef MEM_CTRL_OVF_DETECT_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif
  cmd_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [9:0] wp, rp;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_w(input logic [7:0] d);
    exp_q.push_back({1'b1, 1'b0, 1'b0, wp, d});
    wp++;
  endtask
  task automatic push_r(input logic b);
    exp_q.push_back({1'b0, !b, b, rp, 8'h00});
    rp++;
  endtask
  task automatic do_reset;
    @(posedge clk);
    #1;
    chk("queue_empty_before_reset", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    wp = '0;
    rp = '0;
    #3;
    rst_n = 1'b1;
  endtask
  always @(negedge clk) begin : mon
    cmd_t a, e;
    if (rst_n) begin
      a = {bus.iWriteEnable, bus.Readtoa, bus.Readtob,
           bus.iWriteEnable ? bus.iAddress : bus.iReadAddress,
           bus.iWriteEnable ? bus.validdata : 8'h00};
      chk("strobes_onehot", 32'($countones({a.we, a.ra, a.rb}) < 2), 32'd1);
      if (a.we | a.ra | a.rb) begin
        if (exp_q.size() == 0) chk("unexpected_cmd", 32'(a), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("cmd", 32'(a), 32'(e));
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] pre [4];
    pre = '{8'd16, 8'd32, 8'd64, 8'd128};
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_req_a = 1'b0;
    bus.rd_req_b = 1'b0;
    wp = '0;
    rp = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_strobes", 32'({bus.iWriteEnable, bus.Readtoa, bus.Readtob}), 32'd0);
    chk("rst_addr_data", 32'({bus.iAddress, bus.iReadAddress, bus.validdata}), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_flags", 32'({bus.empty, bus.full, bus.wr_ready, bus.ovf_err}), 32'b1010);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick;
    // single write then single read by A
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'd8;
    chk("wr_ready_idle", 32'(bus.wr_ready), 32'd1);
    push_w(8'd8);
    tick;
    bus.wr_valid = 1'b0;
    chk("count_after_write", 32'(bus.count), 32'd1);
    bus.rd_req_a = 1'b1;
    #1;
    chk("ack_a", 32'({bus.rd_ack_a, bus.rd_ack_b}), 32'b10);
    push_r(1'b0);
    tick;
    bus.rd_req_a = 1'b0;
    chk("count_empty_after_read", 32'({bus.count, bus.empty}), 32'({11'd0, 1'b1}));
    tick;
    // alternation write/read and A/B round-robin
    do_reset;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = pre[i];
      push_w(pre[i]);
      tick;
    end
    bus.wr_data  = 8'hAA;
    bus.rd_req_a = 1'b1;
    bus.rd_req_b = 1'b1;
    #1;
    chk("alt_first_is_read_a", 32'({bus.rd_ack_a, bus.rd_ack_b, bus.wr_ready}), 32'b100);
    push_r(1'b0);
    push_w(8'hAA);
    push_r(1'b1);
    push_w(8'hAA);
    push_r(1'b0);
    repeat (5) tick;
    bus.wr_valid = 1'b0;
    bus.rd_req_a = 1'b0;
    bus.rd_req_b = 1'b0;
    chk("alt_count", 32'(bus.count), 32'd3);
    // fill to full, overflow attempt, wrap both pointers
    do_reset;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      bus.wr_data = 8'(i);
      push_w(8'(i));
      tick;
    end
    chk("full_state", 32'({bus.full, bus.wr_ready, bus.count}), 32'({1'b1, 1'b0, 11'd1024}));
    tick;
    bus.wr_valid = 1'b0;
    chk("ovf_after_full_write", 32'(bus.ovf_err), 32'(OVF));
    bus.rd_req_a = 1'b1;
    push_r(1'b0);
    tick;
    bus.rd_req_a = 1'b0;
    chk("count_after_free", 32'(bus.count), 32'd1023);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h55;
    #1;
    chk("wr_ready_after_free", 32'(bus.wr_ready), 32'd1);
    push_w(8'h55);
    tick;
    bus.wr_valid = 1'b0;
    chk("full_again", 32'(bus.full), 32'd1);
    bus.rd_req_a = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      push_r(1'b0);
      tick;
    end
    bus.rd_req_a = 1'b0;
    chk("drained", 32'({bus.count, bus.empty}), 32'({11'd0, 1'b1}));
    chk("ovf_sticky", 32'(bus.ovf_err), 32'(OVF));
    tick;
    do_reset;
    #1;
    chk("ovf_cleared", 32'(bus.ovf_err), 32'd0);
    // empty: pending B request waits for data
    bus.rd_req_b = 1'b1;
    #1;
    chk("empty_no_ack", 32'(bus.rd_ack_b), 32'd0);
    tick;
    tick;
    chk("empty_still_no_ack", 32'({bus.rd_ack_b, bus.Readtob}), 32'd0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h77;
    push_w(8'h77);
    tick;
    bus.wr_valid = 1'b0;
    chk("ack_b_after_write", 32'({bus.rd_ack_a, bus.rd_ack_b}), 32'b01);
    push_r(1'b1);
    tick;
    bus.rd_req_b = 1'b0;
    tick;
    tick;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
